pulse_to_level: RTL and testbench

- Converts single-cycle strobes into a clean level: either a stretched high window of programmable length, or a toggle per accepted strobe.
- Sits downstream of the edge-to-pulse converters in the EDC path. It turns event strobes back into levels for LEDs, enables and slow-domain consumers.
- Enforces a minimum low gap between windows and flags strobes it cannot honour.

---
 rtl/p2l_pkg.sv | 12 +
 rtl/p2l_down_counter.sv | 28 ++
 rtl/pulse_to_level.sv | 145 ++++++++++++++
 tb/tb_pulse_to_level.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2l_pkg.sv
// Shared constants for the pulse_to_level block: FSM state encoding and the
// output mode selected when a strobe is accepted from IDLE.
package p2l_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic MODE_STRETCH = 1'b0;
    localparam logic MODE_TOGGLE  = 1'b1;

endpackage

// File: rtl/p2l_down_counter.sv
// Loadable down-counter shared by the HOLD and GAP phases. It only counts
// down from a loaded value and parks at zero, so it can never wrap.
module p2l_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_to_level.sv
// Turns single-cycle event strobes back into levels: either a stretched high
// window of programmable length or a toggle per accepted strobe, with an
// enforced low gap after each window and a flag for strobes that are refused.
module pulse_to_level
    import p2l_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int RETRIGGER  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pulse,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_hold_len,
    output logic             o_level,
    output logic             o_busy,
    output logic             o_dropped
);

    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam bit RETRIG  = (RETRIGGER != 0);
    localparam int GAP_M1  = HAS_GAP ? GAP_CYCLES - 1 : 0;
    // Gap reload is zero-extended or truncated to the counter width.
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_M1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             mode;
    logic             mode_nx;
    logic             level_nx;
    logic             dropped_nx;
    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic [CNT_W-1:0] hold_load;

    // A hold length of 0 behaves as 1, so the reload value is N-1 = 0.
    assign hold_load = (i_hold_len == '0) ? '0 : i_hold_len - 1'b1;

    p2l_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    // Next-state, next-output and counter control decode.
    always_comb begin
        state_nx   = state;
        mode_nx    = mode;
        level_nx   = o_level;
        dropped_nx = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        cnt_val    = hold_load;
        case (state)
            IDLE: begin
                if (i_pulse) begin
                    mode_nx = i_mode;
                    if (i_mode == MODE_STRETCH) begin
                        level_nx = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = hold_load;
                        state_nx = HOLD;
                    end else begin
                        level_nx = ~o_level;
                        if (HAS_GAP) begin
                            cnt_load = 1'b1;
                            cnt_val  = GAP_LOAD;
                            state_nx = GAP;
                        end
                    end
                end
            end
            HOLD: begin
                level_nx = 1'b1;
                if (i_pulse && RETRIG) begin
                    // Reload even on the final cycle so the window never glitches low.
                    cnt_load = 1'b1;
                    cnt_val  = hold_load;
                end else begin
                    if (i_pulse) begin
                        dropped_nx = 1'b1;
                    end
                    if (cnt_zero) begin
                        level_nx = 1'b0;
                        if (HAS_GAP) begin
                            cnt_load = 1'b1;
                            cnt_val  = GAP_LOAD;
                            state_nx = GAP;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            GAP: begin
                // After a stretch the level is always low during the gap.
                if (mode == MODE_STRETCH) begin
                    level_nx = 1'b0;
                end
                if (i_pulse) begin
                    dropped_nx = 1'b1;
                end
                if (cnt_zero) begin
                    state_nx = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                level_nx = 1'b0;
            end
        endcase
    end

    // State, latched mode and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            mode      <= MODE_STRETCH;
            o_level   <= 1'b0;
            o_busy    <= 1'b0;
            o_dropped <= 1'b0;
        end else begin
            state     <= state_nx;
            mode      <= mode_nx;
            o_level   <= level_nx;
            o_busy    <= (state_nx != IDLE);
            o_dropped <= dropped_nx;
        end
    end

endmodule

// File: tb/tb_pulse_to_level.sv
// Bench for pulse_to_level: three instances with different gap/retrigger
// settings share one stimulus stream. Directed scenarios use fixed expected
// waveforms; the random scenario uses a remaining-cycles reference model.
module tb_pulse_to_level;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pulse = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] len = 8'd1;
    logic [2:0] lvl, bsy, drp;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining high cycles, remaining gap cycles, toggle level.
    int         GAPS [3] = '{2, 2, 0};
    int         RETR [3] = '{1, 0, 1};
    int         mh [3];
    int         mg [3];
    logic       mt [3];
    logic [2:0] e_lvl, e_bsy, e_drp;

    always #5 clk = ~clk;

    pulse_to_level #(.CNT_W(8), .GAP_CYCLES(2), .RETRIGGER(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_mode(mode), .i_hold_len(len),
        .o_level(lvl[0]), .o_busy(bsy[0]), .o_dropped(drp[0]));

    pulse_to_level #(.CNT_W(8), .GAP_CYCLES(2), .RETRIGGER(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_mode(mode), .i_hold_len(len),
        .o_level(lvl[1]), .o_busy(bsy[1]), .o_dropped(drp[1]));

    pulse_to_level #(.CNT_W(8), .GAP_CYCLES(0), .RETRIGGER(1)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_pulse(pulse), .i_mode(mode), .i_hold_len(len),
        .o_level(lvl[2]), .o_busy(bsy[2]), .o_dropped(drp[2]));

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0;
            mg[i] = 0;
            mt[i] = 1'b0;
        end
        e_lvl = '0;
        e_bsy = '0;
        e_drp = '0;
    endtask

    // One clock cycle: drive inputs, let the DUT sample, advance the model,
    // and return at the following falling edge where outputs are stable.
    task automatic cyc(input logic p, input logic m, input logic [7:0] l);
        int n;
        pulse = p;
        mode  = m;
        len   = l;
        @(posedge clk);
        n = (l == 8'd0) ? 1 : int'(l);
        for (int i = 0; i < 3; i++) begin
            e_drp[i] = 1'b0;
            if (mh[i] > 0) begin
                if (p && RETR[i] == 1) begin
                    mh[i] = n;
                end else begin
                    if (p) e_drp[i] = 1'b1;
                    mh[i] = mh[i] - 1;
                    if (mh[i] == 0) begin
                        mt[i] = 1'b0;
                        mg[i] = GAPS[i];
                    end
                end
            end else if (mg[i] > 0) begin
                if (p) e_drp[i] = 1'b1;
                mg[i] = mg[i] - 1;
            end else if (p) begin
                if (!m) begin
                    mh[i] = n;
                end else begin
                    mt[i] = ~mt[i];
                    mg[i] = GAPS[i];
                end
            end
            e_lvl[i] = (mh[i] > 0) ? 1'b1 : mt[i];
            e_bsy[i] = (mh[i] > 0) || (mg[i] > 0);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pulse = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pulse = k[0];
            @(posedge clk);
            @(negedge clk);
            if ({lvl, bsy, drp} !== 9'd0) begin
                $display("FAIL reset_hold cyc=%0d got lvl=%b bsy=%b drp=%b exp all 0", k, lvl, bsy, drp);
                errors++;
            end
            checks++;
        end
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 8'd5);
            if ({lvl, bsy, drp} !== 9'd0) begin
                $display("FAIL reset_release cyc=%0d got lvl=%b bsy=%b drp=%b exp all 0", k, lvl, bsy, drp);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_stretch();
        int  c;
        logic el, eb;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            cyc(k == 10, 1'b0, 8'd5);
            c  = k + 1;
            el = (c >= 11 && c <= 15);
            eb = (c >= 11 && c <= 17);
            if (lvl[0] !== el || bsy[0] !== eb || drp[0] !== 1'b0) begin
                $display("FAIL stretch cyc=%0d got lvl=%b bsy=%b drp=%b exp lvl=%b bsy=%b drp=0",
                         c, lvl[0], bsy[0], drp[0], el, eb);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_retrigger();
        int  c, s2, last;
        logic el;
        for (int s = 0; s < 2; s++) begin
            s2   = (s == 0) ? 13 : 14;
            last = (s == 0) ? 17 : 18;
            do_reset();
            for (int k = 0; k < 22; k++) begin
                cyc(k == 10 || k == s2, 1'b0, 8'd4);
                c  = k + 1;
                el = (c >= 11 && c <= last);
                if (lvl[0] !== el || drp[0] !== 1'b0) begin
                    $display("FAIL retrigger s2=%0d cyc=%0d got lvl=%b drp=%b exp lvl=%b drp=0",
                             s2, c, lvl[0], drp[0], el);
                    errors++;
                end
                checks++;
            end
        end
    endtask

    task automatic test_no_retrigger();
        int  c;
        logic el, ed, eb;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            cyc(k == 10 || k == 12 || k == 16, 1'b0, 8'd4);
            c  = k + 1;
            el = (c >= 11 && c <= 14);
            eb = (c >= 11 && c <= 16);
            ed = (c == 13 || c == 17);
            if (lvl[1] !== el || bsy[1] !== eb || drp[1] !== ed) begin
                $display("FAIL no_retrigger cyc=%0d got lvl=%b bsy=%b drp=%b exp lvl=%b bsy=%b drp=%b",
                         c, lvl[1], bsy[1], drp[1], el, eb, ed);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_toggle();
        int  c;
        logic el0, eb0, ed0, el2;
        do_reset();
        for (int k = 0; k < 14; k++) begin
            cyc(k == 5 || k == 6 || k == 9, 1'b1, 8'd3);
            c   = k + 1;
            el2 = (c == 6) || (c >= 10);
            el0 = (c >= 6 && c <= 9);
            eb0 = (c == 6 || c == 7 || c == 10 || c == 11);
            ed0 = (c == 7);
            if (lvl[2] !== el2 || bsy[2] !== 1'b0 || drp[2] !== 1'b0) begin
                $display("FAIL toggle_nogap cyc=%0d got lvl=%b bsy=%b drp=%b exp lvl=%b bsy=0 drp=0",
                         c, lvl[2], bsy[2], drp[2], el2);
                errors++;
            end
            checks++;
            if (lvl[0] !== el0 || bsy[0] !== eb0 || drp[0] !== ed0) begin
                $display("FAIL toggle_gap cyc=%0d got lvl=%b bsy=%b drp=%b exp lvl=%b bsy=%b drp=%b",
                         c, lvl[0], bsy[0], drp[0], el0, eb0, ed0);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_boundary();
        int  c;
        logic el;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cyc(k == 2, 1'b0, 8'd0);
            c  = k + 1;
            el = (c == 3);
            if (lvl[0] !== el) begin
                $display("FAIL hold_len_0 cyc=%0d got lvl=%b exp %b", c, lvl[0], el);
                errors++;
            end
            checks++;
        end
        do_reset();
        for (int k = 0; k < 262; k++) begin
            cyc(k == 2, 1'b0, 8'd255);
            c  = k + 1;
            el = (c >= 3 && c <= 257);
            if (lvl[0] !== el) begin
                $display("FAIL hold_len_255 cyc=%0d got lvl=%b exp %b", c, lvl[0], el);
                errors++;
            end
            checks++;
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cyc(k == 0, 1'b0, 8'd20);
        end
        if (lvl !== 3'b111) begin
            $display("FAIL mid_hold_pre got lvl=%b exp 111", lvl);
            errors++;
        end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if (lvl !== 3'b000 || bsy !== 3'b000) begin
            $display("FAIL async_reset got lvl=%b bsy=%b exp 000 000", lvl, bsy);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, 8'd20);
            if (lvl !== 3'b000 || bsy !== 3'b000) begin
                $display("FAIL after_reset cyc=%0d got lvl=%b bsy=%b exp 000 000", k, lvl, bsy);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic       p, m;
        logic [7:0] l;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            p = ($urandom_range(0, 99) < 35);
            m = ($urandom_range(0, 3) == 0);
            l = 8'($urandom_range(0, 7));
            cyc(p, m, l);
            for (int i = 0; i < 3; i++) begin
                if (lvl[i] !== e_lvl[i] || bsy[i] !== e_bsy[i] || drp[i] !== e_drp[i]) begin
                    $display("FAIL random dut=%0d cyc=%0d got lvl=%b bsy=%b drp=%b exp lvl=%b bsy=%b drp=%b",
                             i, n, lvl[i], bsy[i], drp[i], e_lvl[i], e_bsy[i], e_drp[i]);
                    errors++;
                end
                checks++;
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_stretch();
        test_retrigger();
        test_no_retrigger();
        test_toggle();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
